// File: rtl/meas_seq_pkg.sv
// meas_seq_pkg: shared state codes, default phase lengths and timeout flag indices
package meas_seq_pkg;
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_STANDBY  = 3'd1;
  localparam logic [2:0] S_JUDGE    = 3'd2;
  localparam logic [2:0] S_OUTPUT   = 3'd3;
  localparam logic [2:0] S_TRANSMIT = 3'd4;
  localparam int DEF_DEBOUNCE_CYC = 9000;
  localparam int DEF_STANDBY_CYC  = 144000;
  localparam int DEF_JUDGE_CYC    = 7200;
  localparam int DEF_OUTPUT_CYC   = 36000;
  localparam int DEF_TRANSMIT_CYC = 18000;
  localparam int DEF_N_TX         = 2;
  localparam int DEF_TRIG_LEN     = 2;
  localparam int DEF_TX_TRIG_LEN  = 1;
  localparam int DEF_CNT_W        = 18;
  localparam int TO_MEAS   = 0;
  localparam int TO_JUDGE  = 1;
  localparam int TO_OUTPUT = 2;
  localparam int TO_TX     = 3;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: single-cycle press pulse after the key stays low DEBOUNCE_CYC cycles
module key_debounce #(
  parameter int DEBOUNCE_CYC = 9000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int KW = $clog2(DEBOUNCE_CYC + 1);
  logic [KW-1:0] kcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) kcnt <= '0;
    else kcnt <= key_n ? '0 : (kcnt == KW'(DEBOUNCE_CYC)) ? kcnt : kcnt + 1'b1;
  // saturation keeps a held key from firing again
  assign press = !key_n && kcnt == KW'(DEBOUNCE_CYC - 1);
endmodule

// File: rtl/meas_sequencer.sv
// meas_sequencer: measure/judge/output/transmit sequencer with done handshakes,
// sticky timeouts, abort and auto-repeat
module meas_sequencer
  import meas_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int STANDBY_CYC  = DEF_STANDBY_CYC,
  parameter int JUDGE_CYC    = DEF_JUDGE_CYC,
  parameter int OUTPUT_CYC   = DEF_OUTPUT_CYC,
  parameter int TRANSMIT_CYC = DEF_TRANSMIT_CYC,
  parameter int N_TX         = DEF_N_TX,
  parameter int TRIG_LEN     = DEF_TRIG_LEN,
  parameter int TX_TRIG_LEN  = DEF_TX_TRIG_LEN,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_key_n,
  input  logic       abort,
  input  logic       continuous,
  input  logic       meas_done,
  input  logic       judge_done,
  input  logic       output_done,
  input  logic       tx_done,
  output logic       meas_trigger,
  output logic       judge_trigger,
  output logic       output_trigger,
  output logic       transmit_trigger,
  output logic [2:0] tx_index,
  output logic       busy,
  output logic       seq_done,
  output logic [3:0] timeout_flags,
  output logic [2:0] state
);
  localparam logic [CNT_W-1:0] L_SB  = CNT_W'(STANDBY_CYC - 1);
  localparam logic [CNT_W-1:0] L_JG  = CNT_W'(JUDGE_CYC - 1);
  localparam logic [CNT_W-1:0] L_OP  = CNT_W'(OUTPUT_CYC - 1);
  localparam logic [CNT_W-1:0] L_TX  = CNT_W'(TRANSMIT_CYC - 1);
  localparam logic [CNT_W-1:0] TLEN  = CNT_W'(TRIG_LEN);
  localparam logic [CNT_W-1:0] TXLEN = CNT_W'(TX_TRIG_LEN);
  localparam logic [2:0] TX_LAST = 3'(N_TX - 1);
  if (STANDBY_CYC <= TRIG_LEN || JUDGE_CYC <= TRIG_LEN || OUTPUT_CYC <= TRIG_LEN ||
      TRANSMIT_CYC <= TRIG_LEN || TRANSMIT_CYC <= TX_TRIG_LEN || N_TX < 1 || N_TX > 8 ||
      longint'(STANDBY_CYC) > (64'd1 << CNT_W) || longint'(JUDGE_CYC) > (64'd1 << CNT_W) ||
      longint'(OUTPUT_CYC) > (64'd1 << CNT_W) || longint'(TRANSMIT_CYC) > (64'd1 << CNT_W)) begin : g_param_err
    $error("meas_sequencer: illegal parameter combination");
  end
  logic press, timed, done, ext, sd_n;
  logic [CNT_W-1:0] pc, pc_n, lim, tl;
  logic [2:0] ns, tx_n;
  logic [3:0] fl_n;
  logic [1:0] fi;
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key (
    .clk(clk), .rst_n(rst_n), .key_n(start_key_n), .press(press)
  );
  assign busy = state != S_IDLE;
  always_comb begin
    timed = state >= S_STANDBY && state <= S_TRANSMIT;
    lim   = state == S_STANDBY ? L_SB : state == S_JUDGE ? L_JG : state == S_OUTPUT ? L_OP : L_TX;
    done  = state == S_STANDBY ? meas_done : state == S_JUDGE ? judge_done :
            state == S_OUTPUT ? output_done : tx_done;
    fi    = state == S_STANDBY ? 2'(TO_MEAS) : state == S_JUDGE ? 2'(TO_JUDGE) :
            state == S_OUTPUT ? 2'(TO_OUTPUT) : 2'(TO_TX);
    tl    = state == S_TRANSMIT ? TXLEN : TLEN;
    ext   = timed && ((done && pc >= tl) || pc == lim);
    ns    = state;
    pc_n  = pc + 1'b1;
    tx_n  = tx_index;
    fl_n  = timeout_flags;
    sd_n  = 1'b0;
    if (state != S_IDLE && abort) begin
      ns   = S_IDLE;
      pc_n = '0;
      tx_n = '0;
    end else if (state == S_IDLE) begin
      pc_n = '0;
      if (press && !abort) begin
        ns   = S_STANDBY;
        fl_n = '0;
        tx_n = '0;
      end
    end else if (!timed) begin
      ns   = S_IDLE;
      pc_n = '0;
      tx_n = '0;
    end else if (ext) begin
      pc_n = '0;
      if (!done) fl_n[fi] = 1'b1;
      if (state != S_TRANSMIT) ns = state + 3'd1;
      else if (tx_index != TX_LAST) tx_n = tx_index + 3'd1;
      else begin
        sd_n = 1'b1;
        tx_n = '0;
        ns   = continuous ? S_STANDBY : S_IDLE;
        if (continuous) fl_n = '0;
      end
    end
  end
  // triggers are decoded from next state/count so they line up with the state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= S_IDLE;
      pc               <= '0;
      tx_index         <= '0;
      timeout_flags    <= '0;
      seq_done         <= 1'b0;
      meas_trigger     <= 1'b0;
      judge_trigger    <= 1'b0;
      output_trigger   <= 1'b0;
      transmit_trigger <= 1'b0;
    end else begin
      state            <= ns;
      pc               <= pc_n;
      tx_index         <= tx_n;
      timeout_flags    <= fl_n;
      seq_done         <= sd_n;
      meas_trigger     <= ns == S_STANDBY && pc_n < TLEN;
      judge_trigger    <= ns == S_JUDGE && pc_n < TLEN;
      output_trigger   <= ns == S_OUTPUT && pc_n < TLEN;
      transmit_trigger <= ns == S_TRANSMIT && pc_n < TXLEN;
    end
endmodule

// File: tb/tb_meas_sequencer.sv
// tb_meas_sequencer: directed checks of phase timing, handshakes, abort, repeat and reset
module tb_meas_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start_key_n = 1'b1, abort = 1'b0, continuous = 1'b0;
  logic meas_done = 1'b0, judge_done = 1'b0, output_done = 1'b0, tx_done = 1'b0;
  logic meas_trigger, judge_trigger, output_trigger, transmit_trigger, busy, seq_done;
  logic [2:0] tx_index, state;
  logic [3:0] timeout_flags, trig;
  int errors = 0, checks = 0;
  logic [3:0] sb[$];
  logic [3:0] sb_exp;
  meas_sequencer #(
    .DEBOUNCE_CYC(4), .STANDBY_CYC(10), .JUDGE_CYC(5), .OUTPUT_CYC(8), .TRANSMIT_CYC(6),
    .N_TX(2), .TRIG_LEN(2), .TX_TRIG_LEN(1), .CNT_W(18)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_key_n(start_key_n), .abort(abort), .continuous(continuous),
    .meas_done(meas_done), .judge_done(judge_done), .output_done(output_done), .tx_done(tx_done),
    .meas_trigger(meas_trigger), .judge_trigger(judge_trigger), .output_trigger(output_trigger),
    .transmit_trigger(transmit_trigger), .tx_index(tx_index), .busy(busy), .seq_done(seq_done),
    .timeout_flags(timeout_flags), .state(state)
  );
  assign trig = {meas_trigger, judge_trigger, output_trigger, transmit_trigger};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic phase(input logic [2:0] st, input int len, input logic [2:0] tx, input int tlen);
    logic [3:0] e;
    for (int i = 0; i < len; i++) begin
      e = (i < tlen) ? (4'b1000 >> (st - 3'd1)) : 4'b0000;
      chk("phase_state", 32'(state), 32'(st));
      chk("phase_trig", 32'(trig), 32'(e));
      chk("phase_tx_index", 32'(tx_index), 32'(tx));
      chk("phase_busy", 32'(busy), 32'd1);
      tick(1);
    end
  endtask
  task automatic press_and_release();
    start_key_n = 1'b0;
    tick(4);
    start_key_n = 1'b1;
  endtask
  // scoreboard: every seq_done pulse must match a queued expectation of the flags
  always @(negedge clk)
    if (rst_n && seq_done) begin
      if (sb.size() == 0) chk("seq_done_unexpected", 32'(seq_done), 32'd0);
      else begin
        sb_exp = sb.pop_front();
        chk("flags_at_done", 32'(timeout_flags), 32'(sb_exp));
      end
    end
  initial begin
    tick(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'(timeout_flags), 32'd0);
    chk("rst_tx", 32'(tx_index), 32'd0);
    chk("rst_done", 32'(seq_done), 32'd0);
    rst_n = 1'b1;
    tick(2);
    start_key_n = 1'b0;
    tick(3);
    start_key_n = 1'b1;
    tick(3);
    chk("short_key_idle", 32'(state), 32'd0);
    start_key_n = 1'b0;
    sb.push_back(4'b1111);
    tick(4);
    phase(3'd1, 10, 3'd0, 2);
    phase(3'd2, 5, 3'd0, 2);
    phase(3'd3, 8, 3'd0, 2);
    phase(3'd4, 6, 3'd0, 1);
    phase(3'd4, 6, 3'd1, 1);
    chk("seq1_state", 32'(state), 32'd0);
    chk("seq1_done", 32'(seq_done), 32'd1);
    chk("seq1_flags", 32'(timeout_flags), 32'hF);
    chk("seq1_busy", 32'(busy), 32'd0);
    tick(1);
    chk("seq1_done_1cyc", 32'(seq_done), 32'd0);
    tick(10);
    chk("held_key_no_refire", 32'(state), 32'd0);
    start_key_n = 1'b1;
    tick(2);
    press_and_release();
    sb.push_back(4'b1110);
    chk("early_state0", 32'(state), 32'd1);
    tick(1);
    meas_done = 1'b1;
    tick(1);
    chk("early_ignored", 32'(state), 32'd1);
    meas_done = 1'b0;
    tick(1);
    meas_done = 1'b1;
    tick(1);
    meas_done = 1'b0;
    chk("early_flag0", 32'(timeout_flags[0]), 32'd0);
    phase(3'd2, 5, 3'd0, 2);
    phase(3'd3, 8, 3'd0, 2);
    phase(3'd4, 6, 3'd0, 1);
    phase(3'd4, 6, 3'd1, 1);
    chk("early_end_state", 32'(state), 32'd0);
    chk("early_end_flags", 32'(timeout_flags), 32'hE);
    tick(2);
    press_and_release();
    phase(3'd1, 10, 3'd0, 2);
    phase(3'd2, 5, 3'd0, 2);
    tick(4);
    chk("abort_pre_state", 32'(state), 32'd3);
    abort = 1'b1;
    tick(1);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_trig", 32'(trig), 32'd0);
    chk("abort_no_done", 32'(seq_done), 32'd0);
    chk("abort_flags_held", 32'(timeout_flags), 32'h3);
    start_key_n = 1'b0;
    tick(6);
    chk("abort_blocks_press", 32'(state), 32'd0);
    start_key_n = 1'b1;
    abort = 1'b0;
    tick(2);
    chk("abort_idle_after", 32'(state), 32'd0);
    chk("abort_flags_kept", 32'(timeout_flags), 32'h3);
    continuous = 1'b1;
    press_and_release();
    sb.push_back(4'b0000);
    phase(3'd1, 10, 3'd0, 2);
    phase(3'd2, 5, 3'd0, 2);
    phase(3'd3, 8, 3'd0, 2);
    phase(3'd4, 6, 3'd0, 1);
    phase(3'd4, 6, 3'd1, 1);
    chk("cont_state", 32'(state), 32'd1);
    chk("cont_meas_trig", 32'(trig), 32'h8);
    chk("cont_done", 32'(seq_done), 32'd1);
    chk("cont_flags", 32'(timeout_flags), 32'h0);
    continuous = 1'b0;
    sb.push_back(4'b1111);
    phase(3'd1, 10, 3'd0, 2);
    phase(3'd2, 5, 3'd0, 2);
    phase(3'd3, 8, 3'd0, 2);
    phase(3'd4, 6, 3'd0, 1);
    phase(3'd4, 6, 3'd1, 1);
    chk("cont_stop_state", 32'(state), 32'd0);
    chk("cont_stop_done", 32'(seq_done), 32'd1);
    tick(2);
    press_and_release();
    chk("r6_flags_cleared", 32'(timeout_flags), 32'h0);
    phase(3'd1, 10, 3'd0, 2);
    phase(3'd2, 5, 3'd0, 2);
    phase(3'd3, 8, 3'd0, 2);
    phase(3'd4, 6, 3'd0, 1);
    chk("r6_slot1_trig", 32'(trig), 32'h1);
    tick(2);
    chk("r6_pre_state", 32'(state), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_trig", 32'(trig), 32'd0);
    chk("async_rst_tx", 32'(tx_index), 32'd0);
    chk("async_rst_flags", 32'(timeout_flags), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(seq_done), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_state", 32'(state), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
